// File: rtl/wb_intercon_nx_pkg.sv
// wb_intercon_pkg: shared types and helpers for the wb_intercon_nx interconnect.
//   err_cause_t : fault cause codes reported on err_cause_o
//   state_t     : interconnect FSM states
//   addr_match  : base/mask address compare, operands zero-extended to 64 bits
package wb_intercon_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_SLAVE    = 2'd3
  } err_cause_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  localparam int unsigned ADDR_MAX_W    = 64;
  localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

  function automatic logic addr_match(input logic [ADDR_MAX_W-1:0] adr,
                                      input logic [ADDR_MAX_W-1:0] base,
                                      input logic [ADDR_MAX_W-1:0] mask);
    return ((adr & mask) == base);
  endfunction

endpackage

// File: rtl/wb_intercon_nx_addr_decoder.sv
// wb_addr_decoder: combinational priority address decoder.
//   adr    : address to decode
//   onehot : one-hot slave select (lowest matching index wins), zero on miss
//   hit    : any slave matched
module wb_addr_decoder
  import wb_intercon_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned AW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0] BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*AW-1:0] MASK = {32'hFFFF_FF00, 32'hF000_0000, 32'hFF00_0000}
) (
  input  logic [AW-1:0]         adr,
  output logic [NUM_SLAVES-1:0] onehot,
  output logic                  hit
);

  always_comb begin
    onehot = '0;
    hit    = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && addr_match(ADDR_MAX_W'(adr),
                             ADDR_MAX_W'(BASE[i*AW +: AW]),
                             ADDR_MAX_W'(MASK[i*AW +: AW]))) begin
        onehot[i] = 1'b1;
        hit       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_intercon_nx.sv
// wb_intercon_nx: single-master to N-slave Wishbone classic interconnect.
//   clk, reset_n         : clock, asynchronous active-low reset
//   wb_m_*               : master port (request in, dat/ack/err out)
//   wb_s_*               : slave ports; adr/dat/sel broadcast, cyc/stb/we one-hot
//   err_addr_o/cause_o   : address and cause of the most recent fault
//   err_count_o          : saturating fault counter
//   err_clr_i            : synchronous clear of the error log
// The address decode is registered in IDLE, so slaves see the strobe one
// cycle after the request; responses return combinationally.
module wb_intercon_nx
  import wb_intercon_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 3,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK = {32'hFFFF_FF00, 32'hF000_0000, 32'hFF00_0000},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [AW-1:0]              wb_m_adr_i,
  input  logic [DW-1:0]              wb_m_dat_i,
  input  logic [DW/8-1:0]            wb_m_sel_i,
  input  logic                       wb_m_we_i,
  input  logic                       wb_m_cyc_i,
  input  logic                       wb_m_stb_i,
  output logic [DW-1:0]              wb_m_dat_o,
  output logic                       wb_m_ack_o,
  output logic                       wb_m_err_o,
  output logic [NUM_SLAVES*AW-1:0]   wb_s_adr_o,
  output logic [NUM_SLAVES*DW-1:0]   wb_s_dat_o,
  output logic [NUM_SLAVES*DW/8-1:0] wb_s_sel_o,
  output logic [NUM_SLAVES-1:0]      wb_s_we_o,
  output logic [NUM_SLAVES-1:0]      wb_s_cyc_o,
  output logic [NUM_SLAVES-1:0]      wb_s_stb_o,
  input  logic [NUM_SLAVES*DW-1:0]   wb_s_dat_i,
  input  logic [NUM_SLAVES-1:0]      wb_s_ack_i,
  input  logic [NUM_SLAVES-1:0]      wb_s_err_i,
  output logic [AW-1:0]              err_addr_o,
  output logic [1:0]                 err_cause_o,
  output logic [15:0]                err_count_o,
  input  logic                       err_clr_i
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  state_t                  state_q;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic [AW-1:0]           adr_q;
  err_cause_t              pend_q;
  logic [TW-1:0]           tmo_q;
  logic [AW-1:0]           err_addr_q;
  err_cause_t              err_cause_q;
  logic [15:0]             err_count_q;

  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic                    dec_hit;
  logic                    act;
  logic                    sel_ack;
  logic                    sel_err;
  logic [DW-1:0]           sel_dat;
  logic                    tmo_last;
  logic                    fault;
  err_cause_t              fault_cause;

  wb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .AW         (AW),
    .BASE       (SLAVE_BASE),
    .MASK       (SLAVE_MASK)
  ) u_dec (
    .adr    (wb_m_adr_i),
    .onehot (dec_onehot),
    .hit    (dec_hit)
  );

  assign act        = (state_q == ST_ACTIVE);
  assign wb_s_adr_o = {NUM_SLAVES{wb_m_adr_i}};
  assign wb_s_dat_o = {NUM_SLAVES{wb_m_dat_i}};
  assign wb_s_sel_o = {NUM_SLAVES{wb_m_sel_i}};
  assign wb_s_cyc_o = act ? (sel_q & {NUM_SLAVES{wb_m_cyc_i}}) : '0;
  assign wb_s_stb_o = act ? (sel_q & {NUM_SLAVES{wb_m_stb_i}}) : '0;
  assign wb_s_we_o  = act ? (sel_q & {NUM_SLAVES{wb_m_we_i}})  : '0;

  always_comb begin
    sel_dat = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) sel_dat |= wb_s_dat_i[i*DW +: DW];
    end
  end

  assign sel_ack  = |(sel_q & wb_s_ack_i);
  assign sel_err  = |(sel_q & wb_s_err_i);
  assign tmo_last = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // err dominates ack; a dropped cyc silences both, including a pending ERR pulse
  assign wb_m_ack_o = act & wb_m_cyc_i & sel_ack & ~sel_err;
  assign wb_m_err_o = (act & wb_m_cyc_i & sel_err) | ((state_q == ST_ERR) & wb_m_cyc_i);
  assign wb_m_dat_o = act ? sel_dat : '0;

  // Faults are logged in the cycle the error is actually signalled to the master
  always_comb begin
    fault       = 1'b0;
    fault_cause = ERR_NONE;
    if (state_q == ST_ERR && wb_m_cyc_i) begin
      fault       = 1'b1;
      fault_cause = pend_q;
    end else if (act && wb_m_cyc_i && sel_err) begin
      fault       = 1'b1;
      fault_cause = ERR_SLAVE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      adr_q   <= '0;
      pend_q  <= ERR_NONE;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmo_q <= '0;
          if (wb_m_cyc_i && wb_m_stb_i) begin
            sel_q   <= dec_onehot;
            adr_q   <= wb_m_adr_i;
            pend_q  <= ERR_UNMAPPED;
            state_q <= dec_hit ? ST_ACTIVE : ST_ERR;
          end
        end
        ST_ACTIVE: begin
          if (!wb_m_cyc_i || sel_ack || sel_err) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
          end else if (tmo_last) begin
            state_q <= ST_ERR;
            pend_q  <= ERR_TIMEOUT;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_addr_q  <= '0;
      err_cause_q <= ERR_NONE;
      err_count_q <= '0;
    end else if (err_clr_i) begin
      err_addr_q  <= '0;
      err_cause_q <= ERR_NONE;
      err_count_q <= '0;
    end else if (fault) begin
      err_addr_q  <= adr_q;
      err_cause_q <= fault_cause;
      if (err_count_q != ERR_COUNT_MAX) err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_addr_o  = err_addr_q;
  assign err_cause_o = err_cause_q;
  assign err_count_o = err_count_q;

endmodule
